uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_tx_serializer.sv | 149 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, line levels, word limits and frame helpers.
// Used by the TX serializer and the baud generator, and meant to be shared with the RX side.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    localparam int MIN_WORD_WIDTH = 5;
    localparam int MAX_WORD_WIDTH = 9;

    // Total serial bits in one frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int width, input int parity, input int stop);
        return 1 + width + parity + stop;
    endfunction

    // Even parity over a word zero-extended to the widest supported size.
    function automatic logic even_parity(input logic [MAX_WORD_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter with synchronous clear; emits one tick per bit period,
// either at the end of the bit (TX) or near mid-bit (RX sampling).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int G_CLKS_PER_BIT = 16,
    parameter bit G_SAMPLE_MID   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam int CNT_W = $clog2(G_CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(G_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TICK_AT  = G_SAMPLE_MID ? CNT_W'(G_CLKS_PER_BIT / 2 - 1) : LAST_CNT;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    // Next count: held at zero while cleared, wraps at the bit boundary.
    always_comb begin
        cnt_s = cnt_r;
        if (i_clear) begin
            cnt_s = '0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign o_bit_tick = !i_clear && (cnt_r == TICK_AT);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a one-cycle write strobe and byte from the register
// block and shifts out start, data (LSB first), optional even parity and stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int G_WORD_WIDTH   = 8,
    parameter int G_CLKS_PER_BIT = 16,
    parameter int G_PARITY_EN    = 0,
    parameter int G_STOP_BITS    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_tx_en,
    input  logic [G_WORD_WIDTH-1:0] i_tx_reg,
    output logic                    o_tx,
    output logic                    o_busy,
    output logic                    o_tx_done
);

    localparam int BIT_W = $clog2(G_WORD_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(G_WORD_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(G_STOP_BITS - 1);

    tx_state_t               state_r, state_s;
    logic [G_WORD_WIDTH-1:0] shift_r, shift_s;
    logic [BIT_W-1:0]        bit_cnt_r, bit_cnt_s;
    logic                    parity_r, parity_s;
    logic                    tx_r, tx_s;
    logic                    busy_r;
    logic                    done_r, done_s;
    logic                    bit_tick_s;
    logic                    baud_clr_s;

    assign baud_clr_s = (state_r == IDLE);

    uart_baud_gen #(
        .G_CLKS_PER_BIT (G_CLKS_PER_BIT),
        .G_SAMPLE_MID   (1'b0)
    ) u_baud_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (baud_clr_s),
        .o_bit_tick (bit_tick_s)
    );

    // Next-state, shift and counter logic; the bit counter is reused for stop bits.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        parity_s  = parity_r;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_tx_en) begin
                    state_s   = START;
                    shift_s   = i_tx_reg;
                    parity_s  = even_parity(MAX_WORD_WIDTH'(i_tx_reg));
                    bit_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_s   = DATA;
                    bit_cnt_s = '0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    shift_s = {1'b0, shift_r[G_WORD_WIDTH-1:1]};
                    if (bit_cnt_r == LAST_DATA) begin
                        state_s   = (G_PARITY_EN != 0) ? PARITY : STOP;
                        bit_cnt_s = '0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bit_tick_s) begin
                    state_s   = STOP;
                    bit_cnt_s = '0;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    if (bit_cnt_r == LAST_STOP) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so o_tx comes straight from a flop.
    always_comb begin
        tx_s = LINE_IDLE;
        case (state_s)
            IDLE:    tx_s = LINE_IDLE;
            START:   tx_s = LINE_START;
            DATA:    tx_s = shift_s[0];
            PARITY:  tx_s = parity_s;
            STOP:    tx_s = LINE_STOP;
            default: tx_s = LINE_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            parity_r  <= 1'b0;
            tx_r      <= LINE_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            parity_r  <= parity_s;
            tx_r      <= tx_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= done_s;
        end
    end

    assign o_tx      = tx_r;
    assign o_busy    = busy_r;
    assign o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer: two instances (8N1 and 8E2, 4 clocks per bit)
// checked cycle by cycle against frames built from the serial framing rules.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [7:0] reg_a, reg_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;
    logic       sel;
    logic       tx_s, busy_s, done_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .G_WORD_WIDTH(8), .G_CLKS_PER_BIT(CPB), .G_PARITY_EN(0), .G_STOP_BITS(1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(en_a), .i_tx_reg(reg_a),
        .o_tx(tx_a), .o_busy(busy_a), .o_tx_done(done_a)
    );

    uart_tx_serializer #(
        .G_WORD_WIDTH(8), .G_CLKS_PER_BIT(CPB), .G_PARITY_EN(1), .G_STOP_BITS(2)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(en_b), .i_tx_reg(reg_b),
        .o_tx(tx_b), .o_busy(busy_b), .o_tx_done(done_b)
    );

    assign tx_s   = sel ? tx_b   : tx_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (dut %s) t=%0t: got %0h expected %0h", tag, sel ? "b" : "a", $time, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] d);
        if (sel) begin
            en_b  = en;
            reg_b = d;
        end else begin
            en_a  = en;
            reg_a = d;
        end
    endtask

    task automatic start(input logic [7:0] d);
        @(negedge clk);
        drive(1'b1, d);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b0, 8'($urandom));
            check("idle_tx", tx_s, 1);
            check("idle_busy", busy_s, 0);
            check("idle_done", done_s, 0);
        end
    endtask

    // Follows one frame whose strobe was applied on the previous edge.
    // noise_cyc: strobe a random byte in that cycle while busy (0 = none).
    // abort_cyc: stop following after that cycle (0 = full frame).
    // chain: strobe chain_d in the done cycle.
    task automatic run_frame(input logic [7:0] d, input int noise_cyc, input int abort_cyc,
                             input bit chain, input logic [7:0] chain_d);
        bit q[$];
        int total;
        int stop_n;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (sel) q.push_back(($countones(d) % 2) == 1);
        stop_n = sel ? 2 : 1;
        for (int i = 0; i < stop_n; i++) q.push_back(1'b1);
        total = q.size() * CPB;
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            drive(1'b0, 8'($urandom));
            if (c <= total) begin
                check("frame_tx", tx_s, q[(c - 1) / CPB]);
                check("frame_busy", busy_s, 1);
                check("frame_done", done_s, 0);
            end else begin
                check("done_pulse", done_s, 1);
                check("done_busy", busy_s, 0);
                check("done_tx", tx_s, 1);
            end
            if (c == noise_cyc) drive(1'b1, 8'($urandom));
            if (chain && c == total + 1) drive(1'b1, chain_d);
            if (c == abort_cyc) return;
        end
    endtask

    initial begin
        logic [7:0] d, d2;
        int noise;
        bit chain;

        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0; reg_a = 8'h00; reg_b = 8'h00;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        check("rst_tx", tx_s, 1); check("rst_busy", busy_s, 0); check("rst_done", done_s, 0);
        sel = 1'b1;
        check("rst_tx", tx_s, 1); check("rst_busy", busy_s, 0); check("rst_done", done_s, 0);
        rst_n = 1'b1;
        sel = 1'b0;
        idle_check(20);

        // Directed: 0xA5 on 8N1
        start(8'hA5);
        run_frame(8'hA5, 0, 0, 1'b0, 8'h00);
        idle_check(3);

        // Directed: 0x07 on 8E2
        sel = 1'b1;
        start(8'h07);
        run_frame(8'h07, 0, 0, 1'b0, 8'h00);
        idle_check(3);

        // Strobe while busy is ignored
        sel = 1'b0;
        start(8'h3C);
        run_frame(8'h3C, 10, 0, 1'b0, 8'h00);
        idle_check(2 * 10 * CPB);

        // Back-to-back in the done cycle
        start(8'h12);
        run_frame(8'h12, 0, 0, 1'b1, 8'h55);
        run_frame(8'h55, 0, 0, 1'b0, 8'h00);
        idle_check(2);

        // Reset during data bit 3, then a fresh frame
        start(8'hC3);
        run_frame(8'hC3, 0, 4 * CPB + 2, 1'b0, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", tx_a, 1); check("midrst_busy", busy_a, 0); check("midrst_done", done_a, 0);
        rst_n = 1'b1;
        idle_check(12 * CPB);
        start(8'h81);
        run_frame(8'h81, 0, 0, 1'b0, 8'h00);
        idle_check(2);

        // Randomized frames on both configurations
        for (int it = 0; it < 16; it++) begin
            sel   = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            d2    = 8'($urandom);
            noise = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
            chain = 1'($urandom_range(0, 1));
            start(d);
            run_frame(d, noise, 0, chain, d2);
            if (chain) run_frame(d2, 0, 0, 1'b0, 8'h00);
            idle_check(int'($urandom_range(1, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
